// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and access-size helpers for the load/store unit.
// Pure declarations: no latency, no flow control.
package lsu_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_BYTE  = 3'b001;
  localparam logic [2:0] DM_HALF  = 3'b010;
  localparam logic [2:0] DM_BYTEU = 3'b100;
  localparam logic [2:0] DM_HALFU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_RESP
  } lsu_state_e;

  function automatic logic is_valid_ctrl(input logic [2:0] ctrl);
    case (ctrl)
      DM_WORD, DM_BYTE, DM_HALF, DM_BYTEU, DM_HALFU: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
    case (ctrl)
      DM_WORD:           return 3'd4;
      DM_HALF, DM_HALFU: return 3'd2;
      default:           return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane mask, write-data shift and load shift/extend; purely combinational, zero latency.
// No flow control: outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [3:0]  size_mask;
  logic [4:0]  bit_off;
  logic [31:0] rword;

  always_comb begin
    case (size_bytes(ctrl))
      3'd4:    size_mask = 4'hF;
      3'd2:    size_mask = 4'h3;
      default: size_mask = 4'h1;
    endcase
  end

  assign bit_off  = {off, 3'b000};
  assign mask     = {4'b0000, size_mask} << off;
  assign wdata_sh = {32'h0, wdata} << bit_off;
  // Low lanes of the two-word window hold the addressed bytes after the shift.
  assign rword    = 32'(rdata >> bit_off);

  always_comb begin
    case (ctrl)
      DM_BYTE:  rdata_ext = {{24{rword[7]}}, rword[7:0]};
      DM_HALF:  rdata_ext = {{16{rword[15]}}, rword[15:0]};
      DM_BYTEU: rdata_ext = {24'h0, rword[7:0]};
      DM_HALFU: rdata_ext = {16'h0, rword[15:0]};
      default:  rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, 1 or 2 memory cycles, response 2/3 cycles after accept (1 if invalid).
// req_ready only in IDLE; response held stable in RESP until rsp_ready.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int              WIDX_W   = ADDR_W - 2;
  localparam logic [WIDX_W-1:0] WIDX_ONE = 1;

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [WIDX_W-1:0] widx;
  logic [7:0]        mask;
  logic [63:0]       wdata_sh;
  logic [63:0]       rdata_cat;
  logic [31:0]       rdata_ext;
  logic              split;

  assign widx  = addr_q[ADDR_W-1:2];
  assign split = |mask[7:4];
  // In ACC1 the low word was captured in ACC0; otherwise the high word is absent.
  assign rdata_cat = (state_q == ST_ACC1) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};

  lsu_lane_align u_align (
    .ctrl      (ctrl_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (rdata_cat),
    .mask      (mask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      ST_ACC0: begin
        mem_addr  = widx;
        mem_we    = we_q;
        mem_be    = mask[3:0];
        mem_wdata = wdata_sh[31:0];
      end
      ST_ACC1: begin
        mem_addr  = widx + WIDX_ONE;
        mem_we    = we_q;
        mem_be    = mask[7:4];
        mem_wdata = wdata_sh[63:32];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    ctrl_d     = ctrl_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          ctrl_d     = req_ctrl;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rsp_data_d = 32'h0;
          if (!is_valid_ctrl(req_ctrl) || (req_we && req_ctrl[2])) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = ST_ACC0;
          end
        end
      end
      ST_ACC0: begin
        lo_d = mem_rdata;
        if (split) begin
          state_d = ST_ACC1;
        end else begin
          state_d    = ST_RESP;
          rsp_data_d = we_q ? 32'h0 : rdata_ext;
        end
      end
      ST_ACC1: begin
        state_d    = ST_RESP;
        rsp_data_d = we_q ? 32'h0 : rdata_ext;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      ctrl_q      <= DM_WORD;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      lo_q        <= 32'h0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus random requests checked against a byte-level memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ctrl  (req_ctrl),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT: 16 words, aliased by the low word-index bits.
  logic [31:0] tb_mem [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_idx = 4'h0;
  logic [31:0] ld_val = 32'h0;

  assign mem_rdata = tb_mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (ld_en) tb_mem[ld_idx] <= ld_val;
    else if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) tb_mem[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Reference model: byte-addressed view of the same 16-word aliased space.
  logic [31:0] ref_mem [16];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    return ref_mem[a[5:2]][{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
    ref_mem[a[5:2]][{a[1:0], 3'b000} +: 8] = b;
  endtask

  function automatic int nbytes(input logic [2:0] c);
    case (c)
      3'b000:         return 4;
      3'b010, 3'b101: return 2;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] c);
    logic [31:0] v;
    logic [31:0] a;
    v = 32'h0;
    for (int k = 0; k < nbytes(c); k++) begin
      a = addr + 32'(k);
      v[8*k +: 8] = get_byte(a);
    end
    case (c)
      3'b001:  return {{24{v[7]}}, v[7:0]};
      3'b010:  return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  logic [29:0] cyc_addr [2];
  logic [3:0]  cyc_be   [2];
  logic [31:0] cyc_wd   [2];
  int          ncyc;
  logic [31:0] last_data;
  logic        last_err;

  // Issue one request from a negedge, observe every cycle up to the response, then complete the handshake.
  task automatic do_req(input logic we, input logic [2:0] c, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_cyc;
    int          n;
    logic [29:0] exp_a0;
    logic [29:0] exp_a1;
    logic [31:0] a;
    exp_err  = !(c == 3'b000 || c == 3'b001 || c == 3'b010 || c == 3'b100 || c == 3'b101)
               || (we && (c == 3'b100 || c == 3'b101));
    n        = nbytes(c);
    exp_cyc  = exp_err ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
    exp_data = (exp_err || we) ? 32'h0 : ref_load(addr, c);
    exp_a0   = addr[31:2];
    exp_a1   = addr[31:2] + 30'd1;

    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_ctrl = c; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_ctrl = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    ncyc = 0;
    while (!rsp_valid && ncyc < 6) begin
      if (ncyc < 2) begin
        cyc_addr[ncyc] = mem_addr;
        cyc_be[ncyc]   = mem_be;
        cyc_wd[ncyc]   = mem_wdata;
      end
      chk("acc_we", mem_we, we);
      chk("acc_req_ready", req_ready, 1'b0);
      ncyc++;
      @(negedge clk);
    end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
    chk("mem_cycles", ncyc, exp_cyc);
    if (exp_cyc >= 1) chk("acc0_addr", cyc_addr[0], exp_a0);
    if (exp_cyc == 2) chk("acc1_addr", cyc_addr[1], exp_a1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_data", rsp_data, exp_data);
    last_data = rsp_data;
    last_err  = rsp_err;

    if (we && !exp_err)
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        set_byte(a, wdata[8*k +: 8]);
      end

    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_mem_we", mem_we, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [2:0]  c;
    logic [31:0] a;
    logic [2:0]  valid_tbl [5];
    valid_tbl[0] = 3'b000; valid_tbl[1] = 3'b001; valid_tbl[2] = 3'b010;
    valid_tbl[3] = 3'b100; valid_tbl[4] = 3'b101;

    ld_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = (i == 0) ? 32'h44332211 : (i == 1) ? 32'h88776655 : $urandom;
      ld_idx = 4'(i); ld_val = v; ref_mem[i] = v;
      @(negedge clk);
    end
    ld_en = 1'b0;

    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_addr", mem_addr, 30'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 3'b000, 32'h0, 32'h0, 0);
    chk("d_word0", last_data, 32'h44332211);
    chk("d_word0_cyc", ncyc, 1);
    chk("d_word0_be", cyc_be[0], 4'hF);
    do_req(1'b0, 3'b001, 32'h7, 32'h0, 0);
    chk("d_lb7", last_data, 32'hFFFFFF88);
    chk("d_lb7_addr", cyc_addr[0], 30'h1);
    do_req(1'b0, 3'b100, 32'h7, 32'h0, 0);
    chk("d_lbu7", last_data, 32'h00000088);
    chk("d_lbu7_addr", cyc_addr[0], 30'h1);
    do_req(1'b0, 3'b010, 32'h3, 32'h0, 0);
    chk("d_lh3", last_data, 32'h00005544);
    chk("d_lh3_cyc", ncyc, 2);
    chk("d_lh3_a0", cyc_addr[0], 30'h0);
    chk("d_lh3_a1", cyc_addr[1], 30'h1);
    do_req(1'b0, 3'b000, 32'h1, 32'h0, 0);
    chk("d_lw1", last_data, 32'h55443322);

    do_req(1'b1, 3'b000, 32'h2, 32'hAABBCCDD, 0);
    chk("d_sw2_be0", cyc_be[0], 4'b1100);
    chk("d_sw2_wd0", cyc_wd[0], 32'hCCDD0000);
    chk("d_sw2_be1", cyc_be[1], 4'b0011);
    chk("d_sw2_wd1", cyc_wd[1], 32'h0000AABB);
    chk("d_sw2_mem0", tb_mem[0], 32'hCCDD2211);
    chk("d_sw2_mem1", tb_mem[1], 32'h8877AABB);

    do_req(1'b1, 3'b000, 32'hFFFFFFFE, 32'h01020304, 0);
    chk("d_wrap_a0", cyc_addr[0], 30'h3FFFFFFF);
    chk("d_wrap_a1", cyc_addr[1], 30'h0);

    do_req(1'b0, 3'b000, 32'h4, 32'h0, 5);

    do_req(1'b0, 3'b111, 32'h10, 32'h0, 1);
    chk("d_inv_err", last_err, 1'b1);
    chk("d_inv_data", last_data, 32'h0);
    chk("d_inv_cyc", ncyc, 0);
    do_req(1'b1, 3'b101, 32'h10, 32'h12345678, 0);
    chk("d_sthu_err", last_err, 1'b1);

    // Abort a split store during its second memory cycle.
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b000; req_addr = 32'h21; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_acc1_we", mem_we, 1'b1);
    chk("abort_acc1_addr", mem_addr, 30'h9);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_mem_be", mem_be, 4'h0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      a = 32'h21 + 32'(k);
      if (a[31:2] == 30'h8) set_byte(a, req_wdata[8*k +: 8]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_post_ready", req_ready, 1'b1);
      chk("abort_post_valid", rsp_valid, 1'b0);
    end

    for (int t = 0; t < 300; t++) begin
      c = ($urandom_range(0, 5) != 0) ? valid_tbl[$urandom_range(0, 4)] : 3'($urandom);
      do_req(1'($urandom_range(0, 1)), c, $urandom, $urandom, $urandom_range(0, 2));
    end

    for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator for the single-cycle core's data memory. It accepts one load or store request at a time from the datapath using a valid/ready handshake. It splits misaligned accesses that cross a word boundary into two word-wide memory cycles, drives byte-lane enables and shifted write data, and merges and sign- or zero-extends read data into a registered response. It sits between the execute stage and a word-addressed, byte-enabled data memory with combinational read and posedge write.

## Interface
- ADDR_W, 32: byte address width; memory word index width is ADDR_W-2
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_ctrl  in  3  size/sign: 000 word, 001 byte signed, 010 half signed, 100 byte unsigned, 101 half unsigned; others invalid
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  invalid req_ctrl, or store with ctrl 100/101
- mem_addr  out  ADDR_W-2  word index
- mem_we  out  1  write strobe for this cycle
- mem_be  out  4  byte-lane enables (lane i = bits 8i+7:8i)
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  word at mem_addr, same cycle

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. On accept, register we, ctrl, addr, wdata, then go to ACC0. Invalid requests go straight to RESP with rsp_err=1 and no memory cycle.
- Size n bytes = 4/2/1. o = addr[1:0]. 8-bit lane mask M = ((1<<n)-1)<<o. 64-bit shifted data W = wdata<<(8*o).
- Split when M[7:4] != 0: half with o=3, word with o≠0. Bytes never split.
- ACC0: mem_addr = addr[ADDR_W-1:2], mem_be = M[3:0], mem_wdata = W[31:0], mem_we = we. Load captures mem_rdata into lo. Next state is ACC1 if split, otherwise RESP.
- ACC1: mem_addr = ACC0 index+1, modulo 2^(ADDR_W-2), wrapping to 0. mem_be = M[7:4], mem_wdata = W[63:32], mem_we = we. Load captures mem_rdata into hi. Next state is RESP.
- Load result: R = ({hi,lo} >> 8*o)[31:0]; hi=0 if not split. Signed byte/half sign-extends from bit 7/15; unsigned zero-extends.
- RESP: rsp_valid=1, with rsp_data/rsp_err held stable until rsp_ready. On handshake, go to IDLE.
- Outside ACC0/ACC1: mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Accept at edge T:
  - non-split: ACC0 during cycle T+1, rsp_valid from T+2.
  - split: ACC0 in T+1, ACC1 in T+2, rsp_valid from T+3.
  - invalid: rsp_valid from T+1.
- Throughput is one request per 3 or 4 cycles (non-split or split), plus any cycles rsp_ready is held low. The next accept is possible in the cycle after the response handshake.
- Memory outputs are combinational from registered state only. There is no path from req_* to mem_*.
- Reset mid-operation clears state immediately, including mem_we deassertion. The first half of a split store may already be committed; this is allowed. No response is produced for an aborted request.

## Structure
- lsu_pkg: size/sign encodings (DM_WORD=000, DM_BYTE=001, DM_HALF=010, DM_BYTEU=100, DM_HALFU=101), state enum, an is_valid_ctrl function, and a size_bytes function.
- Sub-module lsu_lane_align (combinational): computes the lane mask, the 64-bit shifted write data, and the shift-and-extend of load data. The FSM stays in lsu_ctrl.

## Test plan
- Memory words: mem[0]=0x44332211, mem[1]=0x88776655.
  - Load, ctrl 000, addr 0x0: one memory cycle, rsp_data=0x44332211 at T+2, rsp_err=0.
  - Load, addr 0x7: ctrl 001 gives 0xFFFFFF88; ctrl 100 gives 0x00000088; mem_addr=1 in both.
- Split load, ctrl 010, addr 0x3: mem_addr 0 then 1, rsp_data=0x00005544 at T+3. With ctrl 000 at addr 0x1: 0x55443322.
- Split store, ctrl 000, wdata 0xAABBCCDD, addr 0x2:
  - ACC0: mem_addr 0, be 1100, wdata 0xCCDD0000.
  - ACC1: mem_addr 1, be 0011, wdata 0x0000AABB.
  - Readback: mem[0]=0xCCDD2211, mem[1]=0x8877AABB.
- Wrap: word store at byte address 0xFFFFFFFE (ADDR_W=32) → second cycle mem_addr=0. Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, req_ready=0.
- Invalid ctrl 111 → mem_we never asserted, rsp_err=1, rsp_data=0 at T+1. Reset: pull rst_n low during ACC1 of a split store → mem_we=0 immediately, no rsp_valid, req_ready=1 after release.
